// File: rtl/pulse_train_gen.sv
// pulse_train_gen
//   Emits a burst of single-cycle pulses. A start request in IDLE latches the
//   pulse count and the gap setting; pulses are then separated by period+1
//   idle cycles, so rising edges are period+2 cycles apart. A one-cycle done
//   strobe closes the burst.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   enable     1 = run, 0 = freeze all state (out_pulse/done forced low)
//   start      burst request, honoured only in IDLE
//   count      pulses in the burst, latched at start
//   period     gap setting, latched at start
//   out_pulse  pulse stream, one cycle high per pulse
//   busy       high in PULSE and GAP
//   done       one-cycle strobe at burst completion
//   remaining  pulses not yet emitted in the current burst
//
// state | meaning
// IDLE  | waiting for start
// PULSE | out_pulse high this cycle; remaining decrements at cycle end
// GAP   | inter-pulse spacing, counts r_gap down to 0
// DONE  | single-cycle done strobe, then back to IDLE

module pulse_train_gen #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] period,
  output logic             out_pulse,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] remaining
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_remaining;
  logic [WIDTH-1:0] r_gap;
  logic [WIDTH-1:0] r_gap_len;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_gap       <= '0;
      r_gap_len   <= '0;
    end else if (enable) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_remaining <= count;
            r_gap_len   <= period;
            r_state     <= (count != '0) ? S_PULSE : S_DONE;
          end
        end
        S_PULSE: begin
          // Guarding the decrement keeps remaining from ever wrapping below 0.
          if (r_remaining != '0) begin
            r_remaining <= r_remaining - WIDTH'(1);
          end
          if (r_remaining <= WIDTH'(1)) begin
            r_state <= S_DONE;
          end else begin
            r_state <= S_GAP;
            r_gap   <= r_gap_len;
          end
        end
        S_GAP: begin
          // Counter loaded with period and exits at 0: period+1 gap cycles.
          if (r_gap == '0) begin
            r_state <= S_PULSE;
          end else begin
            r_gap <= r_gap - WIDTH'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Strobes are gated by enable so a frozen PULSE/DONE cycle emits nothing
  // until enable returns; the held state then produces the strobe once.
  assign out_pulse = enable && (r_state == S_PULSE);
  assign done      = enable && (r_state == S_DONE);
  assign busy      = (r_state == S_PULSE) || (r_state == S_GAP);
  assign remaining = r_remaining;

endmodule

// File: tb/tb_pulse_train_gen.sv
module tb_pulse_train_gen;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] count = '0;
  logic [WIDTH-1:0] period = '0;
  logic             out_pulse;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] remaining;

  int n_checks = 0;
  int n_errors = 0;

  pulse_train_gen #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .start     (start),
    .count     (count),
    .period    (period),
    .out_pulse (out_pulse),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: k is the count of enabled cycles since the start edge
  // (k=1 is the first cycle after it). Pulse i sits at k = 1 + i*(p+2).
  function automatic int ref_pulse(input int c, input int p, input int k);
    for (int i = 0; i < c; i++)
      if (1 + i * (p + 2) == k) return 1;
    return 0;
  endfunction

  function automatic int ref_done_k(input int c, input int p);
    return (c == 0) ? 1 : (c - 1) * (p + 2) + 2;
  endfunction

  function automatic int ref_remaining(input int c, input int p, input int k);
    int emitted = 0;
    for (int i = 0; i < c; i++)
      if (1 + i * (p + 2) < k) emitted++;
    return c - emitted;
  endfunction

  // Called at posedge+2 with the DUT idle. Freezes enable for frz_len cycles
  // once the burst reaches active index frz_at. With noise set, start/count/
  // period are scrambled every cycle of the burst.
  task automatic run_burst(input int c, input int p, input int frz_at,
                           input int frz_len, input bit noise);
    int k, dk, frz_left, guard;
    bit en;
    enable = 1'b1;
    start  = 1'b1;
    count  = WIDTH'(c);
    period = WIDTH'(p);
    @(posedge clk); #1;
    start    = 1'b0;
    k        = 1;
    dk       = ref_done_k(c, p);
    frz_left = frz_len;
    guard    = 0;
    forever begin
      en = !(k == frz_at && frz_left > 0);
      if (!en) frz_left--;
      enable = en;
      if (noise) begin
        start  = 1'($urandom_range(0, 1));
        count  = WIDTH'($urandom);
        period = WIDTH'($urandom);
      end
      #1;
      check("out_pulse", out_pulse, en ? ref_pulse(c, p, k) : 0);
      check("done", done, (en && k == dk) ? 1 : 0);
      check("busy", busy, (k < dk) ? 1 : 0);
      check("remaining", remaining, ref_remaining(c, p, k));
      @(posedge clk); #1;
      if (en) begin
        if (k == dk) break;
        k++;
      end
      guard++;
      if (guard > 1000) begin
        check("burst_timeout", 0, 1);
        break;
      end
    end
    start  = 1'b0;
    enable = 1'b1;
    #1;
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_pulse", out_pulse, 0);
    check("idle_remaining", remaining, 0);
  endtask

  initial begin
    #2;
    check("rst_pulse", out_pulse, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_remaining", remaining, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #2;

    run_burst(3, 1, 0, 0, 1'b0);
    run_burst(0, 5, 0, 0, 1'b0);
    run_burst(15, 0, 0, 0, 1'b0);
    run_burst(2, 3, 3, 5, 1'b0);   // freeze inside GAP
    run_burst(3, 2, 1, 4, 1'b0);   // freeze on the first PULSE
    run_burst(4, 2, 5, 3, 1'b0);   // freeze on a later PULSE
    run_burst(5, 2, 0, 0, 1'b1);   // mid-burst start/count/period changes

    // start with enable low in IDLE must not be accepted
    enable = 1'b0;
    start  = 1'b1;
    count  = 4'd5;
    @(posedge clk); #1;
    start  = 1'b0;
    enable = 1'b1;
    #1;
    check("gated_start_busy", busy, 0);
    check("gated_start_rem", remaining, 0);

    // asynchronous reset mid-GAP with remaining=2
    start  = 1'b1;
    count  = 4'd3;
    period = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_busy", busy, 1);
    check("pre_rst_rem", remaining, 2);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_rem", remaining, 0);
    check("async_rst_pulse", out_pulse, 0);
    check("async_rst_done", done, 0);
    start = 1'b1;
    @(posedge clk); #1;
    check("held_rst_busy", busy, 0);
    check("held_rst_done", done, 0);
    start = 1'b0;
    reset = 1'b1;
    #1;
    run_burst(3, 1, 0, 0, 1'b0);

    repeat (25) begin
      run_burst($urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(1, 20), $urandom_range(0, 6), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pulse_train_gen.md
PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

Interface
REQ-001 Parameter: WIDTH, default 4, width of the pulse-count and gap fields.
REQ-002 The block SHALL have exactly the ports in REQ-003 to REQ-012.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  high = run; low = freeze all state.
REQ-006 start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-007 count  input  WIDTH  number of pulses in the burst; captured at start.
REQ-008 period  input  WIDTH  gap setting; captured at start.
REQ-009 out_pulse  output  1  generated pulse stream, one clk cycle high per pulse.
REQ-010 busy  output  1  high while a burst is in progress.
REQ-011 done  output  1  one-cycle strobe when a burst completes.
REQ-012 remaining  output  WIDTH  pulses not yet emitted in the current burst.

Function
REQ-013 The block SHALL implement a four-state FSM: IDLE, PULSE, GAP, DONE.
REQ-014 In IDLE, start=1 with enable=1 SHALL latch count into remaining and period into an internal gap register.
REQ-015 From IDLE on an accepted start, the next state SHALL be PULSE if count!=0 and DONE if count==0.
REQ-016 In PULSE, out_pulse SHALL be 1 for exactly that cycle, and remaining SHALL decrement by 1 at the cycle's end.
REQ-017 From PULSE, the next state SHALL be DONE if remaining==1 before the decrement, else GAP with the gap counter loaded from the latched period.
REQ-018 In GAP, out_pulse SHALL be 0, and the FSM SHALL go to PULSE when the gap counter==0, else decrement the counter and stay in GAP.
REQ-019 The GAP phase SHALL last period+1 cycles, so rising edges of out_pulse are period+2 cycles apart.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-021 busy SHALL be 1 in PULSE and GAP only.
REQ-022 start SHALL be ignored in PULSE, GAP and DONE; a start in the DONE cycle is lost.
REQ-023 With enable=0, the state, remaining and gap counter SHALL hold, and out_pulse, done and start acceptance SHALL be forced to 0.
REQ-024 A frozen PULSE cycle SHALL still emit its single pulse after enable returns, with the pulse count unchanged.
REQ-025 count and period SHALL be unsigned; changes to them after start SHALL NOT affect the running burst.
REQ-026 The maximum burst SHALL be 2^WIDTH-1 pulses; remaining SHALL never wrap below 0.
REQ-027 The latency from the start-sampling edge to the first out_pulse high SHALL be 1 cycle.

Reset
REQ-028 reset=0 SHALL immediately, without waiting for clk, force IDLE with remaining=0, gap counter=0, out_pulse=0, busy=0 and done=0.
REQ-029 Reset during a burst SHALL abort it without asserting done; operation SHALL resume with the first clk edge at which reset=1 and start=1.

Verification
REQ-030 count=3, period=1, start at cycle 0 -> out_pulse high in cycles 1, 4 and 7; done in cycle 8; busy in cycles 1-7; remaining 3,2,2,2,1,1,1,0.
REQ-031 count=0, start -> done in cycle 1, no out_pulse, busy never high.
REQ-032 count=15, period=0 -> 15 pulses 2 cycles apart (cycles 1, 3, ..., 29), done in cycle 30.
REQ-033 count=2, period=3, enable low for 5 cycles during GAP -> out_pulse stays 0 and remaining stays at 1 while frozen; the second pulse is delayed by exactly 5 cycles.
REQ-034 A second start pulsed mid-burst, and count/period changed mid-burst -> no effect on the burst; the pulse total equals the originally latched count.
REQ-035 reset asserted between clk edges in GAP with remaining=2 -> all outputs 0 at once, no done; a later start=1 runs a full new burst.
